// File: rtl/gsu_pkg.sv
// Shared GSU definitions: register index type, special register numbers and
// write-back buffer states.
package gsu_pkg;

   typedef logic [3:0] reg_idx_t;

   localparam reg_idx_t REG_R0  = 4'd0;
   localparam reg_idx_t REG_R14 = 4'd14;
   localparam reg_idx_t REG_R15 = 4'd15;

   // StPend: the held write was refused at least once and is still waiting.
   typedef enum logic [0:0] {StIdle, StPend} wb_state_t;

endpackage

// File: rtl/fig_04b_block_078_wb_hold.sv
// One-entry register-file write buffer with ready handshake and R14/R15
// accept pulses.
module fig_04b_block_078_wb_hold
   import gsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [3:0]  push_addr,
   input  logic [15:0] push_data,
   input  logic        reg_wr_ready,
   output logic        reg_wr_en,
   output logic [3:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        wb_stall,
   output logic        r14_written,
   output logic        r15_written
);

   wb_state_t   state_q, state_d;
   logic        valid_q, valid_d;
   reg_idx_t    addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        accept;
   logic        load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         addr_q  <= REG_R0;
         data_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      accept  = valid_q & reg_wr_ready;
      // A new write loads only into a free slot or one being accepted now;
      // anything offered while stalled or against a refused write is dropped.
      load    = push & (state_q == StIdle) & (~valid_q | reg_wr_ready);
      valid_d = load | (valid_q & ~reg_wr_ready);
      addr_d  = load ? push_addr : addr_q;
      data_d  = load ? push_data : data_q;
      state_d = StIdle;
      if (valid_q && !reg_wr_ready) begin
         state_d = StPend;
      end
   end

   assign reg_wr_en   = valid_q;
   assign reg_wr_addr = addr_q;
   assign reg_wr_data = data_q;
   assign wb_stall    = (state_q == StPend);
   assign r14_written = accept & (addr_q == REG_R14);
   assign r15_written = accept & (addr_q == REG_R15);

endmodule

// File: rtl/fig_04b_block_078_z_writeback.sv
// GSU destination selector: TO/WITH prefix state, MOVE handling and Z-bus
// write-back into the register file through a one-entry buffer.
module fig_04b_block_078_z_writeback
   import gsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] zbus,
   input  logic [15:0] y,
   input  logic [3:0]  nib,
   input  logic        to_set,
   input  logic        with_set,
   input  logic        op_done,
   input  logic        wr_req,
   input  logic        reg_wr_ready,
   output logic        reg_wr_en,
   output logic [3:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic [3:0]  dreg,
   output logic        b_flag,
   output logic        r14_written,
   output logic        r15_written,
   output logic        wb_stall
);

   reg_idx_t    dreg_q, dreg_d;
   logic        b_flag_q, b_flag_d;
   logic        move;
   logic        push;
   reg_idx_t    push_addr;
   logic [15:0] push_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dreg_q   <= REG_R0;
         b_flag_q <= 1'b0;
      end else begin
         dreg_q   <= dreg_d;
         b_flag_q <= b_flag_d;
      end
   end

   always_comb begin
      // A completing instruction clears the prefix first, so a TO arriving
      // alongside op_done is a plain TO rather than a MOVE.
      move      = to_set & b_flag_q & ~op_done & ~with_set;
      push      = (op_done & wr_req) | move;
      push_addr = op_done ? dreg_q : nib;
      push_data = op_done ? zbus : y;

      dreg_d    = dreg_q;
      b_flag_d  = b_flag_q;
      if (op_done || move) begin
         dreg_d   = REG_R0;
         b_flag_d = 1'b0;
      end
      if (with_set) begin
         dreg_d   = nib;
         b_flag_d = 1'b1;
      end else if (to_set && !move) begin
         dreg_d   = nib;
      end
   end

   assign dreg   = dreg_q;
   assign b_flag = b_flag_q;

   fig_04b_block_078_wb_hold u_hold (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .push_addr    (push_addr),
      .push_data    (push_data),
      .reg_wr_ready (reg_wr_ready),
      .reg_wr_en    (reg_wr_en),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .wb_stall     (wb_stall),
      .r14_written  (r14_written),
      .r15_written  (r15_written)
   );

endmodule

// File: tb/tb_fig_04b_block_078_z_writeback.sv
// Self-checking bench for the GSU Z write-back block: directed scenarios then
// constrained-random traffic against a behavioural model.
module tb_fig_04b_block_078_z_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] zbus = '0;
   logic [15:0] y = '0;
   logic [3:0]  nib = '0;
   logic        to_set = 1'b0;
   logic        with_set = 1'b0;
   logic        op_done = 1'b0;
   logic        wr_req = 1'b0;
   logic        reg_wr_ready = 1'b0;
   logic        reg_wr_en;
   logic [3:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;
   logic [3:0]  dreg;
   logic        b_flag;
   logic        r14_written;
   logic        r15_written;
   logic        wb_stall;

   int checks = 0;
   int errors = 0;

   // Model: the write currently presented on the port, whether it has been
   // refused, the prefix state, and per-register accepted-write counts.
   logic        m_valid;
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   logic        m_refused;
   logic [3:0]  m_dreg;
   logic        m_b;
   int          acc_cnt [16];

   always #5 clk = ~clk;

   fig_04b_block_078_z_writeback dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .zbus         (zbus),
      .y            (y),
      .nib          (nib),
      .to_set       (to_set),
      .with_set     (with_set),
      .op_done      (op_done),
      .wr_req       (wr_req),
      .reg_wr_ready (reg_wr_ready),
      .reg_wr_en    (reg_wr_en),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .dreg         (dreg),
      .b_flag       (b_flag),
      .r14_written  (r14_written),
      .r15_written  (r15_written),
      .wb_stall     (wb_stall)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid   = 1'b0;
      m_addr    = 4'd0;
      m_data    = 16'h0;
      m_refused = 1'b0;
      m_dreg    = 4'd0;
      m_b       = 1'b0;
      foreach (acc_cnt[i]) acc_cnt[i] = 0;
   endtask

   task automatic check_outputs();
      chk("reg_wr_en", {15'd0, reg_wr_en}, {15'd0, m_valid});
      chk("reg_wr_addr", {12'd0, reg_wr_addr}, {12'd0, m_addr});
      chk("reg_wr_data", reg_wr_data, m_data);
      chk("dreg", {12'd0, dreg}, {12'd0, m_dreg});
      chk("b_flag", {15'd0, b_flag}, {15'd0, m_b});
      chk("wb_stall", {15'd0, wb_stall}, {15'd0, m_refused});
   endtask

   // One clock cycle of stimulus; the model advances across the rising edge.
   task automatic step(input logic t, input logic w, input logic od, input logic wr,
                       input logic rdy, input logic [3:0] n, input logic [15:0] z,
                       input logic [15:0] yv);
      logic is_move, wants_write, accepted;
      @(negedge clk);
      to_set = t; with_set = w; op_done = od; wr_req = wr;
      reg_wr_ready = rdy; nib = n; zbus = z; y = yv;
      #1;
      accepted    = m_valid && rdy;
      is_move     = t && m_b && !od && !w;
      wants_write = (od && wr) || is_move;
      chk("r14_written", {15'd0, r14_written}, {15'd0, accepted && m_addr == 4'd14});
      chk("r15_written", {15'd0, r15_written}, {15'd0, accepted && m_addr == 4'd15});
      if (od || is_move) chk("no_stall_at_issue", {15'd0, wb_stall}, 16'd0);
      if (accepted) acc_cnt[m_addr]++;
      m_refused = m_valid && !rdy;
      if (wants_write && (!m_valid || rdy)) begin
         m_valid = 1'b1;
         m_addr  = od ? m_dreg : n;
         m_data  = od ? z : yv;
      end else if (accepted) begin
         m_valid = 1'b0;
      end
      if (od || is_move) begin
         m_dreg = 4'd0;
         m_b    = 1'b0;
      end
      if (w) begin
         m_dreg = n;
         m_b    = 1'b1;
      end else if (t && !is_move) begin
         m_dreg = n;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 4'd0, 16'h0, 16'h0);
   endtask

   initial begin
      logic t, w, od, wr, rdy;
      int   r;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;

      // Plain op_done to R0.
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h1234, 16'h0);
      chk("first_write_addr", {12'd0, reg_wr_addr}, 16'd0);
      chk("first_write_data", reg_wr_data, 16'h1234);
      idle(1'b1);

      // TO R5 then op_done.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 16'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'hBEEF, 16'h0);
      chk("to5_addr", {12'd0, reg_wr_addr}, 16'd5);
      chk("to5_data", reg_wr_data, 16'hBEEF);
      idle(1'b1);

      // WITH R3 then TO R9 is a MOVE of y.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 16'h0, 16'h00A5);
      chk("move_addr", {12'd0, reg_wr_addr}, 16'd9);
      chk("move_data", reg_wr_data, 16'h00A5);
      idle(1'b1);

      // R15 then R14 writes held off by three refused cycles.
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (k == 0) ? 4'd15 : 4'd14, 16'h0, 16'h0);
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h8000, 16'h0);
         repeat (3) idle(1'b0);
         idle(1'b1);
         idle(1'b1);
      end
      chk("r15_accept_count", acc_cnt[15][15:0], 16'd1);
      chk("r14_accept_count", acc_cnt[14][15:0], 16'd1);

      // op_done without wr_req after TO R7.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0, 16'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h7777, 16'h0);
      chk("no_write_en", {15'd0, reg_wr_en}, 16'd0);

      // op_done with TO R4 in the same cycle, after TO R6.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 16'h0, 16'h0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 16'h1111, 16'h0);
      chk("simul_old_dreg", {12'd0, reg_wr_addr}, 16'd6);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h2222, 16'h0);
      chk("simul_next_dreg", {12'd0, reg_wr_addr}, 16'd4);
      idle(1'b1);

      // Reset while a write is pending.
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h5A5A, 16'h0);
      idle(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", {15'd0, reg_wr_en}, 16'd0);
      chk("rst_stall", {15'd0, wb_stall}, 16'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      idle(1'b1);

      // Back-to-back writes with ready tied high.
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'(k * 16'h0101), 16'h0);
      end

      // Constrained-random traffic that respects the sequencer protocol.
      for (int k = 0; k < 3000; k++) begin
         r   = int'($urandom_range(0, 9));
         rdy = ($urandom_range(0, 3) != 0);
         od  = ($urandom_range(0, 2) == 0);
         wr  = $urandom_range(0, 1) != 0;
         t   = (r < 3);
         w   = (r == 3);
         if (m_valid && !(rdy && !m_refused)) begin
            od = 1'b0;
            if (m_b) t = 1'b0;
         end
         step(t, w, od, wr, rdy, 4'($urandom_range(0, 15)), 16'($urandom),
              16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
